// File: rtl/cache_pkg.sv
// cache_pkg: shared frame geometry, counter widths and the enums used by the
// cache sequencer and its result buffer.
//   WIDTH, HEIGHT      default frame size in pixels (4 pixels per cache word)
//   ROW_WORDS          cache words per frame row
//   FRAME_WORDS        cache words per frame (reads issued per frame)
//   OUT_WORDS          window results per frame (writes issued per frame)
//   seq_state_e        sequencer FSM states
//   seq_op_e           cache operation selected in a cycle
package cache_pkg;

  localparam int WIDTH       = 352;
  localparam int HEIGHT      = 288;
  localparam int ROW_WORDS   = WIDTH / 4;
  localparam int FRAME_WORDS = WIDTH * HEIGHT / 4;
  localparam int OUT_WORDS   = FRAME_WORDS - 2 * ROW_WORDS;

  localparam int CNT_W  = 16;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_FLUSH,
    S_FIN
  } seq_state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_WR
  } seq_op_e;

endpackage

// File: rtl/seq_res_fifo.sv
// seq_res_fifo: result buffer between the processing core and the cache
// write port. First-word-fall-through; data_o shows the head entry.
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push_i     store data_i (dropped if full and not popping)
//   data_i     result word
//   pop_i      remove head entry (ignored if empty)
//   data_o     head entry
//   count_o    current occupancy, 0..DEPTH
//   full_o     occupancy == DEPTH
//   empty_o    occupancy == 0
module seq_res_fifo
  import cache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is allowed only when a pop frees the slot.
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cache_sequencer.sv
// cache_sequencer: drives a 3-row line cache through one frame. It primes the
// first two rows, then interleaves window reads with write-back of processed
// results, throttled by a credit scheme so the result buffer never overflows.
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle frame request (honoured only when idle)
//   busy              frame in progress
//   done              one-cycle frame-complete pulse
//   cache_en/we       cache operation request / write select
//   cache_di          cache write data (buffer head on a write, else 0)
//   cache_finish      cache address-counter reset pulse
//   win_valid         cache 3-row window output is valid this cycle
//   res_valid/data    result from the processing core
//   res_ready         result buffer has space
module cache_sequencer #(
  parameter int WIDTH        = cache_pkg::WIDTH,
  parameter int HEIGHT       = cache_pkg::HEIGHT,
  parameter int MEMORY_DELAY = 2,
  parameter int RES_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        cache_en,
  output logic        cache_we,
  output logic [31:0] cache_di,
  output logic        cache_finish,
  output logic        win_valid,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready
);

  import cache_pkg::*;

  localparam int ROW_N   = WIDTH / 4;
  localparam int FRAME_N = WIDTH * HEIGHT / 4;
  localparam int OUT_N   = FRAME_N - 2 * ROW_N;
  localparam int PRIME_N = 2 * ROW_N;
  localparam int RD_LAT  = MEMORY_DELAY + 1;
  localparam int OCC_W   = $clog2(RES_DEPTH + 1);

  seq_state_e        state_q, state_d;
  seq_op_e           op;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [OCC_W-1:0]  infl_q, infl_d;
  logic              fresh_q, fresh_d;
  logic [RD_LAT-1:0] win_sr_q;

  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    used;
  logic [31:0]       fifo_head;
  logic              fifo_full, fifo_empty;
  logic              accept, win_rd, credit_ok, reads_left, last_rd, last_wr;

  seq_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (res_data),
    .pop_i   (op == OP_WR),
    .data_o  (fifo_head),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign res_ready = !fifo_full;
  assign accept    = res_valid && res_ready;

  // Each window read owns one buffer slot from issue until its result is
  // written back, so in-flight reads plus occupancy may never pass RES_DEPTH.
  assign used       = {1'b0, infl_q} + {1'b0, occ};
  assign credit_ok  = used < (OCC_W + 1)'(RES_DEPTH);
  assign reads_left = rd_cnt_q < CNT_W'(FRAME_N);
  assign last_rd    = rd_cnt_q == CNT_W'(FRAME_N - 1);
  assign last_wr    = wr_cnt_q == CNT_W'(OUT_N - 1);
  // Only reads past the first two rows complete a 3-row window.
  assign win_rd     = (op == OP_RD) && (rd_cnt_q >= CNT_W'(PRIME_N));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    fresh_d  = fresh_q;
    infl_d   = infl_q;
    op       = OP_NONE;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PRIME;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end
      end
      S_PRIME: begin
        op      = OP_RD;
        fresh_d = 1'b0;
        if (rd_cnt_q == CNT_W'(PRIME_N - 1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        // Drain early when half full so reads are not starved of credit later.
        if (!fifo_empty && (occ >= OCC_W'(RES_DEPTH / 2) || !reads_left || !credit_ok)) begin
          op = OP_WR;
        end else if (reads_left && credit_ok) begin
          op = OP_RD;
        end else if (!fifo_empty) begin
          op = OP_WR;
        end
        if (op == OP_RD && last_rd) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (!fifo_empty) op = OP_WR;
        if (op == OP_WR && last_wr) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (op == OP_RD) rd_cnt_d = rd_cnt_q + 1'b1;
    if (op == OP_WR) wr_cnt_d = wr_cnt_q + 1'b1;

    case ({win_rd, accept})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      infl_q   <= '0;
      fresh_q  <= 1'b1;
      win_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      infl_q   <= infl_d;
      fresh_q  <= fresh_d;
      // Tracks the cache read pipeline; truncation drops the oldest stage.
      win_sr_q <= RD_LAT'({win_sr_q, win_rd});
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign cache_en  = (op != OP_NONE);
  assign cache_we  = (op == OP_WR);
  assign cache_di  = (op == OP_WR) ? fifo_head : 32'd0;
  assign win_valid = win_sr_q[RD_LAT-1];
  // The first frame after reset also rewinds the cache address counters.
  assign cache_finish = done || (state_q == S_PRIME && fresh_q);

endmodule

// File: tb/tb_cache_sequencer.sv
`timescale 1ns/1ps
module tb_cache_sequencer;

  logic        clk     = 1'b0;
  logic [1:0]  rst_v   = 2'b11;
  logic [1:0]  start_v = 2'b00;
  logic [1:0]  clr_v   = 2'b00;
  int          lat_v [2] = '{1, 1};
  logic [1:0]  busy_v, done_v, en_v, we_v, fin_v, win_v, rdy_v;
  logic [31:0] di_v [2];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // Instance 0: default 352x288 frame. Instance 1: 16x4 frame.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W   = (g == 0) ? 352 : 16;
    localparam int H   = (g == 0) ? 288 : 4;
    localparam int PN  = W / 2;
    localparam int RDL = 3;
    localparam int DEP = 4;

    logic        rv = 1'b0;
    logic [31:0] res_d = '0;
    logic        rdy_seen = 1'b0;
    int          due_q[$];
    logic [31:0] dat_q[$];
    int          exp_win[$];
    int cyc = 0;
    int f_rd = 0, f_wr = 0, f_acc = 0, f_win = 0, f_wrd = 0, f_busy = 0;
    int n_rd = 0, n_wr = 0, n_win = 0, n_prime = 0, n_done = 0, n_fin = 0, n_fin_done = 0;
    int data_err = 0, win_err = 0, credit_err = 0, empty_err = 0, rdy_low = 0, en_err = 0;
    int first_wrd = -1, first_lat = -1;

    cache_sequencer #(
      .WIDTH        (W),
      .HEIGHT       (H),
      .MEMORY_DELAY (2),
      .RES_DEPTH    (DEP)
    ) u_dut (
      .clk          (clk),
      .rst          (rst_v[g]),
      .start        (start_v[g]),
      .busy         (busy_v[g]),
      .done         (done_v[g]),
      .cache_en     (en_v[g]),
      .cache_we     (we_v[g]),
      .cache_di     (di_v[g]),
      .cache_finish (fin_v[g]),
      .win_valid    (win_v[g]),
      .res_valid    (rv),
      .res_data     (res_d),
      .res_ready    (rdy_v[g])
    );

    // Core model and monitor, evaluated mid-cycle.
    always @(negedge clk) begin
      cyc++;
      if (clr_v[g]) begin
        n_rd = 0; n_wr = 0; n_win = 0; n_prime = 0; n_done = 0; n_fin = 0; n_fin_done = 0;
        data_err = 0; win_err = 0; credit_err = 0; empty_err = 0; rdy_low = 0; en_err = 0;
        first_wrd = -1; first_lat = -1;
      end
      if (rst_v[g]) begin
        rv = 1'b0; rdy_seen = 1'b0;
        due_q.delete(); dat_q.delete(); exp_win.delete();
        f_rd = 0; f_wr = 0; f_acc = 0; f_win = 0; f_wrd = 0; f_busy = 0;
      end else begin
        if (rv && rdy_seen) begin
          due_q.delete(0); dat_q.delete(0); f_acc++;
        end
        if (!rdy_v[g]) rdy_low++;
        if (exp_win.size() != 0 && exp_win[0] == cyc) begin
          if (!win_v[g]) win_err++;
          exp_win.delete(0);
        end else if (win_v[g]) begin
          win_err++;
        end
        if (win_v[g]) begin
          if (first_lat < 0 && first_wrd >= 0) first_lat = cyc - first_wrd;
          due_q.push_back(cyc + lat_v[g]);
          dat_q.push_back({16'hA5A5, f_win[15:0]});
          f_win++; n_win++;
        end
        if (en_v[g] && !we_v[g]) begin
          if (f_rd >= PN) begin
            if (first_wrd < 0) first_wrd = cyc;
            exp_win.push_back(cyc + RDL);
            f_wrd++;
            if (f_wrd - f_wr > DEP) credit_err++;
          end
          if (f_busy < PN) n_prime++;
          f_rd++; n_rd++;
        end
        if (en_v[g] && we_v[g]) begin
          if (f_acc == f_wr) empty_err++;
          if (di_v[g] !== {16'hA5A5, f_wr[15:0]}) data_err++;
          f_wr++; n_wr++;
        end
        if (en_v[g] && (!busy_v[g] || done_v[g])) en_err++;
        if (busy_v[g]) f_busy++;
        if (fin_v[g]) n_fin++;
        if (done_v[g]) begin
          n_done++;
          if (fin_v[g]) n_fin_done++;
        end
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
          rv = 1'b1; res_d = dat_q[0]; rdy_seen = rdy_v[g];
        end else begin
          rv = 1'b0;
        end
        if (done_v[g]) begin
          f_rd = 0; f_wr = 0; f_acc = 0; f_win = 0; f_wrd = 0; f_busy = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g);
    start_v[g] = 1'b1;
    tick();
    start_v[g] = 1'b0;
  endtask

  task automatic clear_stats(input int g);
    clr_v[g] = 1'b1;
    tick();
    clr_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    int n = 0;
    while (!done_v[g] && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, done_v[g], 1);
  endtask

  task automatic check_idle(input int g, input string tag);
    check({tag, "_busy"}, busy_v[g], 0);
    check({tag, "_done"}, done_v[g], 0);
    check({tag, "_en"},   en_v[g],   0);
    check({tag, "_we"},   we_v[g],   0);
    check({tag, "_fin"},  fin_v[g],  0);
    check({tag, "_win"},  win_v[g],  0);
    check({tag, "_di"},   di_v[g],   0);
    check({tag, "_rdy"},  rdy_v[g],  1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Default-size frame, core answers one cycle after win_valid.
    repeat (3) tick();
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    rst_v = 2'b00;
    tick();
    pulse_start(0);
    check("big_busy_rise", busy_v[0], 1);
    check("big_entry_finish", fin_v[0], 1);
    wait_done(0, 70000, "big");
    check("big_fin_at_done", fin_v[0], 1);
    tick();
    check("big_busy_after", busy_v[0], 0);
    check("big_done_width", done_v[0], 0);
    check("big_reads", g_dut[0].n_rd, 25344);
    check("big_prime_reads", g_dut[0].n_prime, 176);
    check("big_writes", g_dut[0].n_wr, 25168);
    check("big_windows", g_dut[0].n_win, 25168);
    check("big_first_win_lat", g_dut[0].first_lat, 3);
    check("big_win_timing", g_dut[0].win_err, 0);
    check("big_data_order", g_dut[0].data_err, 0);
    check("big_done_cnt", g_dut[0].n_done, 1);
    check("big_finish_cnt", g_dut[0].n_fin, 2);
    check("big_en_idle", g_dut[0].en_err, 0);

    // 16x4 frame: 8 PRIME reads, 8 writes.
    pulse_start(1);
    check("sm_entry_finish", fin_v[1], 1);
    wait_done(1, 500, "sm");
    check("sm_fin_at_done", fin_v[1], 1);
    tick();
    check("sm_prime_reads", g_dut[1].n_prime, 8);
    check("sm_reads", g_dut[1].n_rd, 16);
    check("sm_writes", g_dut[1].n_wr, 8);
    check("sm_data_order", g_dut[1].data_err, 0);
    check("sm_finish_cnt", g_dut[1].n_fin, 2);
    check("sm_fin_done", g_dut[1].n_fin_done, 1);

    // Slow core: ten-cycle result latency.
    lat_v[1] = 10;
    clear_stats(1);
    pulse_start(1);
    check("slow_no_entry_finish", fin_v[1], 0);
    wait_done(1, 1000, "slow");
    tick();
    check("slow_ready_low", g_dut[1].rdy_low, 0);
    check("slow_credit", g_dut[1].credit_err, 0);
    check("slow_empty_wr", g_dut[1].empty_err, 0);
    check("slow_writes", g_dut[1].n_wr, 8);
    check("slow_data_order", g_dut[1].data_err, 0);
    check("slow_win_timing", g_dut[1].win_err, 0);

    // Start pulses while busy are ignored.
    lat_v[1] = 1;
    clear_stats(1);
    pulse_start(1);
    repeat (3) tick();
    pulse_start(1);
    repeat (8) tick();
    pulse_start(1);
    wait_done(1, 500, "ign");
    repeat (4) tick();
    check("ign_busy_after", busy_v[1], 0);
    check("ign_done_cnt", g_dut[1].n_done, 1);
    check("ign_reads", g_dut[1].n_rd, 16);
    check("ign_writes", g_dut[1].n_wr, 8);

    // Back-to-back frames.
    clear_stats(1);
    pulse_start(1);
    wait_done(1, 500, "b2b1");
    tick();
    pulse_start(1);
    check("b2b_accept", busy_v[1], 1);
    wait_done(1, 500, "b2b2");
    tick();
    check("b2b_done_cnt", g_dut[1].n_done, 2);
    check("b2b_writes", g_dut[1].n_wr, 16);
    check("b2b_data", g_dut[1].data_err, 0);
    check("b2b_finish_cnt", g_dut[1].n_fin, 2);

    // Reset in STREAM after the second write, then a full clean frame.
    clear_stats(1);
    pulse_start(1);
    begin
      int n = 0;
      while (g_dut[1].n_wr < 2 && n < 500) begin
        tick();
        n++;
      end
      check("abort_reach_wr2", g_dut[1].n_wr, 2);
    end
    rst_v[1] = 1'b1;
    tick();
    check_idle(1, "abort");
    rst_v[1] = 1'b0;
    check("abort_no_done", g_dut[1].n_done, 0);
    clear_stats(1);
    pulse_start(1);
    check("restart_entry_finish", fin_v[1], 1);
    wait_done(1, 500, "restart");
    tick();
    check("restart_reads", g_dut[1].n_rd, 16);
    check("restart_prime", g_dut[1].n_prime, 8);
    check("restart_writes", g_dut[1].n_wr, 8);
    check("restart_data", g_dut[1].data_err, 0);
    check("restart_done_cnt", g_dut[1].n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
